// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite requester arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: arb_state_t FSM encoding and the AXI response codes used by the arbiter.
package axi4_lite_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_rr_picker.sv
// Combinational requester picker: one-hot winner from a request vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the winner is used.
// Ports: req (request vector), ptr (last-served index), winner (one-hot, 0 when no req).
// Build option AXIL_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins), ptr ignored.
module axi4_lite_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner
);

`ifdef AXIL_ARB_FIXED_PRIO_EN
  // Pointer has no meaning here; fold it into a sink so it is visibly intentional.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Walk from the top down so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end
`else
  logic found;

  // Search order is ptr+1, ptr+2, ... wrapping; the first requester hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite master between NUM_REQ requesters, one transaction at a time.
// Latency: grant 1 cycle after req in IDLE, start pulse with grant, done 1 cycle after R/B handshake.
// Backpressure: requesters hold req until done; the master is never restarted before completion.
// Ports: ACLK/ARESET (async, active-high); req/req_we/req_addr/req_wdata in; gnt/done/rsp_* out;
//        START_READ/START_WRITE/address/W_data to master; M_R*/M_B* are bus monitor taps.
// Build option AXIL_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin (no pointer register).
module axi4_lite_req_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          START_READ,
  output logic                          START_WRITE,
  output logic [ADDRESS_WIDTH-1:0]      address,
  output logic [DATA_WIDTH-1:0]         W_data,
  input  logic                          M_RVALID,
  input  logic                          M_RREADY,
  input  logic                          M_BVALID,
  input  logic                          M_BREADY,
  input  logic [DATA_WIDTH-1:0]         M_RDATA,
  input  logic [1:0]                    M_RRESP,
  input  logic [1:0]                    M_BRESP
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t               state;
  logic                     cmd_we;
  logic [NUM_REQ-1:0]       pick;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic                     sel_we;
  logic [PTR_W-1:0]         ptr;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0]         pick_idx;
  logic [PTR_W-1:0]         win_idx;

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end
`endif

  axi4_lite_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick)
  );

  // One-hot mux of the winning requester's command.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_addr  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = req_we[i];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      cmd_we      <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= RESP_OKAY;
      START_READ  <= 1'b0;
      START_WRITE <= 1'b0;
      address     <= '0;
      W_data      <= '0;
`ifdef AXIL_ARB_FIXED_PRIO_EN
`else
      // Pointing at the last requester makes requester 0 the first winner.
      ptr         <= PTR_W'(NUM_REQ - 1);
      win_idx     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt         <= pick;
            cmd_we      <= sel_we;
            address     <= sel_addr;
            W_data      <= sel_wdata;
            // Start is registered with the grant so it is high exactly for the ISSUE cycle.
            START_WRITE <= sel_we;
            START_READ  <= ~sel_we;
`ifdef AXIL_ARB_FIXED_PRIO_EN
`else
            win_idx     <= pick_idx;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          START_WRITE <= 1'b0;
          START_READ  <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          // Only the handshake matching the latched command type completes it.
          if (!cmd_we && M_RVALID && M_RREADY) begin
            rsp_rdata <= M_RDATA;
            rsp_resp  <= M_RRESP;
            done      <= gnt;
            state     <= RESP;
          end else if (cmd_we && M_BVALID && M_BREADY) begin
            rsp_rdata <= '0;
            rsp_resp  <= M_BRESP;
            done      <= gnt;
            state     <= RESP;
          end
        end
        RESP: begin
          done      <= '0;
          gnt       <= '0;
          cmd_we    <= 1'b0;
          address   <= '0;
          W_data    <= '0;
          rsp_rdata <= '0;
          rsp_resp  <= RESP_OKAY;
`ifdef AXIL_ARB_FIXED_PRIO_EN
`else
          ptr       <= win_idx;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_lite_req_arbiter.md
# axi4_lite_req_arbiter

Round-robin arbiter that shares one `axi4_lite_master` between `NUM_REQ` local requesters. It grants one requester at a time and latches that requester's command. It then drives the master's start/address/data controls and watches the AXI read-data and write-response handshakes to detect completion. Finally it returns read data and response to the granted requester with a one-cycle done pulse.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, range 2..16.
- `ADDRESS_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.

Ports:
- `ACLK`  in  1  clock. One clock domain; reset is asynchronous and active-high.
- `ARESET`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request; held high until that requester's `done`.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i at slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `gnt`  out  NUM_REQ  one-hot grant, high from latch through the `done` cycle.
- `done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `rsp_rdata`  out  DATA_WIDTH  read data, valid with `done`; 0 for writes.
- `rsp_resp`  out  2  RRESP or BRESP, valid with `done`.
- `START_READ`, `START_WRITE`  out  1  start controls to the master.
- `address`  out  ADDRESS_WIDTH  latched address to the master.
- `W_data`  out  DATA_WIDTH  latched write data to the master.
- `M_RVALID`, `M_RREADY`, `M_BVALID`, `M_BREADY`  in  1  bus monitor taps.
- `M_RDATA`  in  DATA_WIDTH  bus monitor tap.
- `M_RRESP`, `M_BRESP`  in  2  bus monitor taps.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req` is high, pick a winner with the round-robin picker and latch `addr`, `wdata` and `we` into `cmd_*` registers.
  - Set `gnt[winner]` and go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - Assert exactly one start for one cycle: `START_WRITE` if `cmd_we`, else `START_READ`.
  - Go to WAIT.
- WAIT:
  - Read: when `M_RVALID && M_RREADY`, capture `M_RDATA` and `M_RRESP`, go to RESP.
  - Write: when `M_BVALID && M_BREADY`, capture `M_BRESP`, set rdata to 0, go to RESP.
  - The handshake of the other type is ignored.
- RESP:
  - `done[winner]` = 1 for this cycle; `rsp_*` carry the captured values.
  - Update the last-served pointer to the winner; go to IDLE.
- Round-robin: search starts at last+1 modulo NUM_REQ. The pointer resets to NUM_REQ-1, so requester 0 wins first.
- `address` and `W_data` hold the latched command from ISSUE through RESP. The master drives them combinationally, so they must not change mid-transaction. They are 0 in IDLE.
- `req` is sampled only in IDLE.
  - Dropping `req` mid-transaction does not abort; the transaction completes and `done` still pulses.
  - `req_*` changes after the latch are ignored.

## Timing
- Reset values: state IDLE; `gnt`, `done`, `START_*` = 0; `address`, `W_data`, `rsp_rdata`, `rsp_resp` = 0; pointer = NUM_REQ-1.
- Reset is asynchronous; asserting it in any state returns to IDLE immediately, with no `done` for the aborted transaction. The master must be reset in the same event.
- Cycle sequence:
  - `req` high in IDLE at edge e0 → `gnt` high after e0.
  - `START_*` high for the cycle e0..e1.
  - WAIT from e1.
  - Handshake seen at edge ek → `done` high for ek..ek+1.
  - IDLE after ek+1.
- Minimum spacing between `done` pulses: a new grant can latch in the first IDLE cycle after RESP, so two `done` pulses are at least 4 cycles apart.
- Simultaneous requests at the same edge are resolved by round-robin only; read/write type has no priority.

## Configuration
- `AXIL_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. The pointer register is removed and starvation is possible.
  - Undefined (default): round-robin as above.

## Structure
- Package `axi4_lite_arb_pkg`:
  - `arb_state_t` enum for IDLE/ISSUE/WAIT/RESP.
  - Response constants `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
- Sub-module `axi4_lite_rr_picker`:
  - Combinational; inputs are the request vector and pointer; output is a one-hot winner.
  - Contains the `AXIL_ARB_FIXED_PRIO_EN` branch.

## Test plan
- Single read: req[1], addr 0x10; slave returns RDATA 0xDEADBEEF, RRESP 0 → `gnt`=4'b0010, one `START_READ` pulse, `address`=0x10 stable, `done[1]` with rdata 0xDEADBEEF.
- Write with error: req[2], we, addr 0x20, wdata 0xA5A5A5A5; slave BRESP=2'b10 → one `START_WRITE` pulse, `W_data` stable, `done[2]` with resp 2'b10 and rdata 0.
- Contention: req[0] and req[2] held high from reset → order 0, 2, 0, 2; no overlapping `gnt`; `done` pulses at least 4 cycles apart.
- Fixed priority (macro defined): same stimulus as contention → requester 0 served repeatedly; requester 2 only after req[0] drops.
- Reset mid-WAIT: `ARESET` asserted 3 cycles after ISSUE → all outputs 0 asynchronously, no `done`; after release requester 0 wins first.
- Request drop: req[3] deasserted in WAIT → transaction completes and `done[3]` still pulses once.
